// File: rtl/sine_track_pkg.sv
// Shared helpers for the sine DC tracker: midscale reset value and the
// derived widths of the window counter and the extremum accumulators.
package sine_track_pkg;

    function automatic int midscale(input int data_w);
        return 1 << (data_w - 1);
    endfunction

    function automatic int sum_width(input int data_w, input int avg_log2);
        return data_w + avg_log2;
    endfunction

    function automatic int cnt_width(input int win_len);
        return (win_len > 2) ? $clog2(win_len) : 1;
    endfunction

endpackage

// File: rtl/sine_dc_tracker_if.sv
// Sample stream in, DC-removed stream and window statistics out.
interface sine_dc_tracker_if #(
    parameter int DATA_W = 12
);
    logic                     restart;
    logic                     in_valid;
    logic [DATA_W-1:0]        sample;
    logic                     out_valid;
    logic signed [DATA_W:0]   shifted;
    logic [DATA_W-1:0]        max_avg;
    logic [DATA_W-1:0]        min_avg;
    logic [DATA_W-1:0]        mid;
    logic [DATA_W-1:0]        amp;
    logic                     update_pulse;
    logic                     locked;

    modport master (
        output restart, in_valid, sample,
        input  out_valid, shifted, max_avg, min_avg, mid, amp, update_pulse, locked
    );

    modport slave (
        input  restart, in_valid, sample,
        output out_valid, shifted, max_avg, min_avg, mid, amp, update_pulse, locked
    );
endinterface

// File: rtl/sine_dc_tracker_window_extrema.sv
// Per-window sample index plus running max/min; the effective extremes
// include the current sample so the last sample of a window still counts.
module window_extrema
    import sine_track_pkg::*;
#(
    parameter int DATA_W  = 12,
    parameter int WIN_LEN = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] wmax_eff,
    output logic [DATA_W-1:0] wmin_eff,
    output logic              last_sample
);
    localparam int CW = cnt_width(WIN_LEN);
    localparam logic [CW-1:0] IDX_LAST = CW'(WIN_LEN - 1);

    logic [CW-1:0]     idx_reg;
    logic [DATA_W-1:0] win_max_reg;
    logic [DATA_W-1:0] win_min_reg;
    logic              first_sample;

    // Index 0 starts a fresh window, so stale extremes are ignored there.
    assign first_sample = (idx_reg == '0);
    assign last_sample  = (idx_reg == IDX_LAST);
    assign wmax_eff     = (first_sample || sample > win_max_reg) ? sample : win_max_reg;
    assign wmin_eff     = (first_sample || sample < win_min_reg) ? sample : win_min_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            idx_reg     <= '0;
            win_max_reg <= '0;
            win_min_reg <= '0;
        end else if (in_valid) begin
            win_max_reg <= wmax_eff;
            win_min_reg <= wmin_eff;
            idx_reg     <= last_sample ? '0 : idx_reg + 1'b1;
        end
    end
endmodule

// File: rtl/sine_dc_tracker.sv
// Averages window max/min over 2^AVG_LOG2 windows (shift only) and removes
// the estimated midpoint from the incoming sample stream.
module sine_dc_tracker
    import sine_track_pkg::*;
#(
    parameter int DATA_W   = 12,
    parameter int WIN_LEN  = 40,
    parameter int AVG_LOG2 = 3
) (
    input logic               clk,
    input logic               rst,
    sine_dc_tracker_if.slave  bus
);
    localparam int SUM_W = sum_width(DATA_W, AVG_LOG2);
    localparam int WC_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [WC_W-1:0]   WIN_LAST = WC_W'((1 << AVG_LOG2) - 1);
    localparam logic [DATA_W-1:0] MIDSCALE = DATA_W'(midscale(DATA_W));

    logic [DATA_W-1:0]      wmax_eff;
    logic [DATA_W-1:0]      wmin_eff;
    logic                   last_sample;

    logic [SUM_W-1:0]       max_sum_reg;
    logic [SUM_W-1:0]       min_sum_reg;
    logic [WC_W-1:0]        win_cnt_reg;
    logic [DATA_W-1:0]      max_avg_reg;
    logic [DATA_W-1:0]      min_avg_reg;
    logic [DATA_W-1:0]      mid_reg;
    logic [DATA_W-1:0]      amp_reg;
    logic                   update_pulse_reg;
    logic                   locked_reg;
    logic                   out_valid_reg;
    logic signed [DATA_W:0] shifted_reg;

    logic [SUM_W-1:0]       max_total;
    logic [SUM_W-1:0]       min_total;
    logic [DATA_W-1:0]      max_avg_next;
    logic [DATA_W-1:0]      min_avg_next;
    logic [DATA_W:0]        mid_sum;
    logic [DATA_W-1:0]      mid_next;
    logic [DATA_W-1:0]      amp_next;
    logic signed [DATA_W:0] shifted_next;
    logic                   final_window;

    window_extrema #(
        .DATA_W  (DATA_W),
        .WIN_LEN (WIN_LEN)
    ) u_window_extrema (
        .clk         (clk),
        .rst         (rst),
        .clear       (bus.restart),
        .in_valid    (bus.in_valid),
        .sample      (bus.sample),
        .wmax_eff    (wmax_eff),
        .wmin_eff    (wmin_eff),
        .last_sample (last_sample)
    );

    // The closing window is folded in combinationally so all averages,
    // mid and amp land on the same edge.
    assign max_total    = max_sum_reg + SUM_W'(wmax_eff);
    assign min_total    = min_sum_reg + SUM_W'(wmin_eff);
    assign max_avg_next = DATA_W'(max_total >> AVG_LOG2);
    assign min_avg_next = DATA_W'(min_total >> AVG_LOG2);
    assign mid_sum      = {1'b0, max_avg_next} + {1'b0, min_avg_next};
    assign mid_next     = DATA_W'(mid_sum >> 1);
    assign amp_next     = max_avg_next - min_avg_next;
    assign final_window = (win_cnt_reg == WIN_LAST);
    assign shifted_next = $signed({1'b0, bus.sample}) - $signed({1'b0, mid_reg});

    always_ff @(posedge clk) begin
        if (rst) begin
            max_sum_reg      <= '0;
            min_sum_reg      <= '0;
            win_cnt_reg      <= '0;
            max_avg_reg      <= '0;
            min_avg_reg      <= '0;
            mid_reg          <= MIDSCALE;
            amp_reg          <= '0;
            update_pulse_reg <= 1'b0;
            locked_reg       <= 1'b0;
            out_valid_reg    <= 1'b0;
            shifted_reg      <= '0;
        end else begin
            update_pulse_reg <= 1'b0;
            out_valid_reg    <= bus.in_valid;
            if (bus.in_valid) begin
                shifted_reg <= shifted_next;
            end
            // Restart drops the partial statistics but keeps published results.
            if (bus.restart) begin
                max_sum_reg <= '0;
                min_sum_reg <= '0;
                win_cnt_reg <= '0;
                locked_reg  <= 1'b0;
            end else if (bus.in_valid && last_sample) begin
                if (final_window) begin
                    max_avg_reg      <= max_avg_next;
                    min_avg_reg      <= min_avg_next;
                    mid_reg          <= mid_next;
                    amp_reg          <= amp_next;
                    max_sum_reg      <= '0;
                    min_sum_reg      <= '0;
                    win_cnt_reg      <= '0;
                    update_pulse_reg <= 1'b1;
                    locked_reg       <= 1'b1;
                end else begin
                    max_sum_reg <= max_total;
                    min_sum_reg <= min_total;
                    win_cnt_reg <= win_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign bus.out_valid    = out_valid_reg;
    assign bus.shifted      = shifted_reg;
    assign bus.max_avg      = max_avg_reg;
    assign bus.min_avg      = min_avg_reg;
    assign bus.mid          = mid_reg;
    assign bus.amp          = amp_reg;
    assign bus.update_pulse = update_pulse_reg;
    assign bus.locked       = locked_reg;
endmodule

// File: doc/sine_dc_tracker.md
Name: sine_dc_tracker

Overview:
Parametrised successor of the single-channel sine min/max midpoint estimator. Tracks per-window max/min of an unsigned sampled sinusoid and averages them over 2^AVG_LOG2 windows. Publishes max/min averages, midpoint, amplitude and a lock flag, plus a signed, DC-removed copy of the input stream. Sits between the ADC sample interface and the phase/frequency tracking stages of phase_2. Adds over the previous generation: sample-valid qualification, restart, shift-based averaging, an update strobe and a midscale pre-lock midpoint.

Parameters:
DATA_W, 12, input sample width (unsigned)
WIN_LEN, 40, samples per window (one nominal sine period); must be >= 2
AVG_LOG2, 3, log2 of windows averaged (8 windows); 0 means a single window

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
restart  in  1  discard the partial accumulation and restart the window sequence
in_valid  in  1  sample qualifier
sample  in  DATA_W  unsigned input sample
out_valid  out  1  shifted is valid; in_valid delayed by 1 cycle
shifted  out  DATA_W+1 signed  sample minus mid
max_avg  out  DATA_W  averaged window maximum
min_avg  out  DATA_W  averaged window minimum
mid  out  DATA_W  floor((max_avg+min_avg)/2)
amp  out  DATA_W  max_avg-min_avg
update_pulse  out  1  one-cycle strobe when averages/mid/amp change
locked  out  1  set by the first completed average; cleared by rst/restart

Behaviour:
- Reset values: out_valid=0, shifted=0, max_avg=0, min_avg=0, amp=0, mid=2^(DATA_W-1), update_pulse=0, locked=0. Internal counters, sums and window registers are cleared.
- Priority: rst > restart > in_valid. All state holds while in_valid=0. update_pulse defaults to 0.
- Window: sample index idx counts 0..WIN_LEN-1 on valid samples.
  - Effective extremes: wmax_eff = sample if idx=0, else max(win_max, sample); wmin_eff likewise with min. The first and last samples of a window both count.
  - win_max/win_min <= wmax_eff/wmin_eff on every valid sample.
- End of window (valid sample with idx=WIN_LEN-1):
  - idx <= 0, win_cnt++.
  - max_sum += wmax_eff, min_sum += wmin_eff. Sum width is DATA_W+AVG_LOG2, so no overflow.
- Final window (win_cnt = 2^AVG_LOG2-1):
  - max_avg <= (max_sum+wmax_eff) >> AVG_LOG2 (floor); min_avg likewise.
  - mid and amp are computed from these new averages at the same edge: mid = (new_max+new_min)>>1 using a DATA_W+1 bit intermediate; amp = new_max-new_min (always >= 0).
  - Sums and win_cnt <= 0; update_pulse <= 1; locked <= 1.
  - All outputs change together; none lags the others.
- Shifted path: on valid, shifted <= $signed({1'b0,sample}) - $signed({1'b0,mid}), using the mid value held before the edge; out_valid <= in_valid. While in_valid=0, shifted holds.
- restart=1:
  - idx, win_cnt, sums and window registers <= 0; locked <= 0.
  - max_avg/min_avg/mid/amp are retained.
  - A sample in the restart cycle is excluded from the statistics but still produces shifted/out_valid.
- rst at a window's last sample: no update occurs and all reset values apply.
- No divider: averaging is a shift only.

Decomposition:
- Package sine_track_pkg: midscale function, sum-width function (DATA_W+AVG_LOG2), counter-width function ($clog2(WIN_LEN)).
- One natural sub-module, window_extrema: idx counter plus win_max/win_min, emitting wmax_eff/wmin_eff and a last_sample flag. The top level holds the averaging, outputs and shifted path.

Test Plan:
(All with DATA_W=12, WIN_LEN=4, AVG_LOG2=1.)
1. Reset, then one valid sample 3000 -> next cycle: out_valid=1, shifted=952, mid=2048, locked=0, max_avg=min_avg=amp=0.
2. Eight contiguous valid samples {100,200,300,400}x2 -> after the 8th edge: max_avg=400, min_avg=100, mid=250, amp=300, update_pulse high for exactly 1 cycle, locked=1. Next sample 250 -> shifted=0; sample 0 -> shifted=-250.
3. Windows {4095,9,8,0} and {1,4094,7,6} (extremes at the first and last positions) -> max_avg=4094, min_avg=0, mid=2047, amp=4094.
4. Scenario 2 stimulus with in_valid high every other cycle -> identical final values, update_pulse on the edge of the 8th valid sample, out_valid mirrors in_valid delayed by 1.
5. After lock from scenario 2: 5 valid samples, restart, then {10,20,30,40}x2 -> locked=0 from the restart until the 8th new sample; mid stays 250 until then, then becomes 25; the restart-cycle sample does not affect the averages.
6. rst asserted together with a window's final sample -> next cycle all outputs at reset values, no update_pulse; a subsequent full 8 samples lock normally.
